// File: rtl/if_prefetch_buf.sv
// rtl/if_prefetch_buf.sv - instruction-fetch prefetch FIFO with redirect flush and stale-response drain
// Optional same-cycle response bypass when the FIFO is empty: define IF_PREFETCH_BYPASS_EN.
module if_prefetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst,
  output logic [63:0] curr_pc,
  output logic        ena
);
  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state;
  logic          req_en;
  logic [63:0]   fetch_pc, rsp_pc, redirect_tgt;
  logic [63:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, outstanding, drop_cnt, drop_src, drop_next;
  logic [CW:0]   credit_used;
  logic          head_valid, req_fire, rsp_take, bypass, push, pop;

  assign redirect_tgt   = redirect_pc & ~64'h3;
  assign head_valid     = (count != '0);
  // Buffered plus in-flight words may never exceed the FIFO size, so a push always has room.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = req_en && (state == RUN) && !redirect_valid &&
                          (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = (state == RUN) && !redirect_valid && imem_rsp_valid &&
                          (outstanding != '0);
`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass = rsp_take && !head_valid;
`else
  assign bypass = 1'b0;
`endif
  assign pop  = head_valid && !stall && !redirect_valid;
  assign push = rsp_take && !(bypass && !stall);

  // In RUN drop_cnt is 0; in DRAIN outstanding is 0. A response in the redirect cycle is already stale.
  assign drop_src  = (state == RUN) ? outstanding : drop_cnt;
  assign drop_next = (imem_rsp_valid && drop_src != '0) ? drop_src - CW'(1) : drop_src;

  always_comb begin
    ena     = head_valid;
    inst    = NOP;
    curr_pc = '0;
    if (head_valid) begin
      inst    = inst_mem[rd_ptr];
      curr_pc = pc_mem[rd_ptr];
    end else if (bypass) begin
      ena     = 1'b1;
      inst    = imem_rsp_data;
      curr_pc = rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      inst_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      req_en      <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      req_en <= 1'b1;
      if (redirect_valid) begin
        fetch_pc    <= redirect_tgt;
        rsp_pc      <= redirect_tgt;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        outstanding <= '0;
        drop_cnt    <= drop_next;
        state       <= (drop_next != '0) ? DRAIN : RUN;
      end else if (state == DRAIN) begin
        if (imem_rsp_valid && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state <= RUN;
        end
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'd4;
        if (rsp_take) rsp_pc   <= rsp_pc + 64'd4;
        if (push)     wr_ptr   <= wr_ptr + PW'(1);
        if (pop)      rd_ptr   <= rd_ptr + PW'(1);
        outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
        count       <= count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
